tcm_arbiter: RTL and testbench
==============================

// Module: tcm_arbiter
// PURPOSE
//  Shares one single-port DFFRAM between the core's instruction and data req/gnt/rvalid ports.
//  Picks one requester per cycle, grants it, drives the RAM enable, write mask, address and data.
//  Returns rvalid/rdata/err to the owner one cycle later.
//  Lets instruction and data accesses target one unified tightly-coupled memory.
// PARAMETERS
//  MemAw     10            word-address width of the RAM (depth = 2**MemAw words)
//  BaseAddr  32'h2000_0000 byte base address of the memory window
//  MaxStall  4             consecutive instr losses before instr is forced to win (1..15)
// PORTS
//  clk_i           in   1      clock
//  rst_ni          in   1      async active-low reset
//  instr_req_i     in   1      instr request
//  instr_gnt_o     out  1      instr grant (combinational, same cycle)
//  instr_addr_i    in   32     instr byte address
//  instr_rvalid_o  out  1      instr response valid
//  instr_rdata_o   out  32     instr read data
//  instr_err_o     out  1      instr error, qualified by rvalid
//  data_req_i      in   1      data request
//  data_gnt_o      out  1      data grant (combinational, same cycle)
//  data_we_i       in   1      data write enable
//  data_be_i       in   4      data byte enables
//  data_addr_i     in   32     data byte address
//  data_wdata_i    in   32     data write data
//  data_rvalid_o   out  1      data response valid (reads and writes)
//  data_rdata_o    out  32     data read data
//  data_err_o      out  1      data error, qualified by rvalid
//  mem_en_o        out  1      RAM chip enable
//  mem_we_o        out  4      RAM byte write mask
//  mem_addr_o      out  MemAw  RAM word address
//  mem_wdata_o     out  32     RAM write data
//  mem_rdata_i     in   32     RAM read data, valid the cycle after a read with mem_en_o
// BEHAVIOUR
//  - Reset: all rvalid/err outputs 0; rdata 0; owner register = OWN_NONE; stall counter 0.
//  - Arbitration: combinational. At most one gnt per cycle, and a gnt is only driven while its req is high.
//    Data wins by default. Instr wins whenever the stall counter equals MaxStall.
//  - Stall counter increments when instr_req_i is high and instr loses. It clears on an instr grant
//    or when instr_req_i is low. It saturates at MaxStall.
//  - In range: (addr - BaseAddr) < 4*2**MemAw. Word index = (addr - BaseAddr)[MemAw+1:2]; addr[1:0] is ignored.
//  - Granted in-range access: mem_en_o = 1.
//    mem_we_o = data_be_i when the data port writes, 4'b0 otherwise; the instr port never writes.
//    mem_addr_o = word index; mem_wdata_o = data_wdata_i.
//  - Granted out-of-range access: it is granted but mem_en_o stays 0. Next cycle rvalid = 1, err = 1, rdata = 0.
//  - Idle cycles: mem_en_o = 0, mem_we_o = 0. mem_addr_o and mem_wdata_o hold their last values (no toggling).
//  - Response: fixed 1-cycle latency. An owner register (owner_e) and an err flag are registered on gnt.
//    The next cycle raises rvalid on the owner's port only. rdata = mem_rdata_i for a read, 0 for a write.
//    The non-owner port sees rvalid 0 and rdata 0.
//  - Back-to-back: a new gnt is allowed in the same cycle the previous rvalid is driven (full throughput).
//  - Simultaneous requests: the loser's req stays high and it is granted on a later cycle.
//    The counter guarantees instr is granted within MaxStall+1 cycles.
//  - Reset mid-access: the in-flight response is dropped and no rvalid follows reset release.
// CONFIGURATION
//  TCM_ARB_RR_EN defined: strict round-robin on contention. A last-winner bit flips on every contended grant.
//    The stall counter is removed and MaxStall is ignored.
//  TCM_ARB_RR_EN undefined: data-priority with the MaxStall starvation guard described above.
// STRUCTURE
//  tcm_arb_pkg: owner_e {OWN_NONE, OWN_INSTR, OWN_DATA}; localparam WordBytes = 4;
//    function in_range(addr, base, aw).
//  Sub-module tcm_arb_sel: grant select holding the stall counter / RR bit; outputs the winner.
//  The top level holds the mem-side muxing, the owner/err response registers and the rdata steering.
// TESTING
//  1. Instr-only read 0x2000_0010 with RAM word 4 = 0xDEAD_BEEF -> gnt same cycle, mem_addr 4, mem_we 0;
//     next cycle instr_rvalid 1, rdata 0xDEAD_BEEF, err 0.
//  2. Data write 0x2000_0008, be 4'b0011, wdata 0x1234_5678 -> mem_we 4'b0011, mem_addr 2;
//     next cycle data_rvalid 1, rdata 0.
//  3. Both req held for 10 cycles, MaxStall 4 -> pattern D,D,D,D,I repeats. No instr wait exceeds 5 cycles.
//     With TCM_ARB_RR_EN the grants alternate D,I,D,I.
//  4. Data read 0x2000_1000 (MemAw 10, out of range) -> gnt 1, mem_en 0; next cycle data_rvalid 1, err 1, rdata 0.
//  5. rst_ni low during the cycle after a grant -> no rvalid on either port after release; counter and owner reset.
//  6. Instr requests every cycle alone -> gnt every cycle, rvalid every cycle after the first, sequential data correct.

Source files
------------

// File: rtl/tcm_arb_pkg.sv
// rtl/tcm_arb_pkg.sv - shared types and helpers for the TCM arbiter
package tcm_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam int WordBytes = 4;

  // 33-bit compare so the window size cannot wrap to zero for large aw
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input int aw);
    logic [32:0] span;
    span = 33'(WordBytes) << aw;
    return {1'b0, addr - base} < span;
  endfunction

endpackage

// File: rtl/tcm_arb_sel.sv
// rtl/tcm_arb_sel.sv - winner select; TCM_ARB_RR_EN selects round-robin instead of data-priority
module tcm_arb_sel #(
  parameter int MaxStall = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic instr_req_i,
  input  logic data_req_i,
  output logic instr_win_o,
  output logic data_win_o
);

`ifdef TCM_ARB_RR_EN
  // Starts as "instr won last" so the first contended grant goes to data
  logic last_instr_q, last_instr_d;

  always_comb begin
    instr_win_o  = 1'b0;
    data_win_o   = 1'b0;
    last_instr_d = last_instr_q;
    if (instr_req_i && data_req_i) begin
      instr_win_o  = !last_instr_q;
      data_win_o   = last_instr_q;
      last_instr_d = !last_instr_q;
    end else begin
      instr_win_o = instr_req_i;
      data_win_o  = data_req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_instr_q <= 1'b1;
    end else begin
      last_instr_q <= last_instr_d;
    end
  end
`else
  localparam logic [3:0] StallMax = 4'(MaxStall);

  logic [3:0] stall_q, stall_d;

  always_comb begin
    instr_win_o = 1'b0;
    data_win_o  = 1'b0;
    stall_d     = stall_q;
    if (instr_req_i && data_req_i) begin
      instr_win_o = (stall_q == StallMax);
      data_win_o  = (stall_q != StallMax);
    end else begin
      instr_win_o = instr_req_i;
      data_win_o  = data_req_i;
    end
    if (!instr_req_i || instr_win_o) begin
      stall_d = 4'd0;
    end else if (stall_q != StallMax) begin
      stall_d = stall_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= 4'd0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule

// File: rtl/tcm_arbiter.sv
// rtl/tcm_arbiter.sv - instr/data arbiter for one single-port TCM (TCM_ARB_RR_EN: round-robin)
module tcm_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int          MemAw    = 10,
  parameter logic [31:0] BaseAddr = 32'h2000_0000,
  parameter int          MaxStall = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  output logic             instr_gnt_o,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic             mem_en_o,
  output logic [3:0]       mem_we_o,
  output logic [MemAw-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  logic             instr_win, data_win, granted, sel_in_range;
  logic [31:0]      sel_addr, sel_off;
  logic [MemAw-1:0] sel_word;
  logic [MemAw-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  owner_e           owner_q, owner_d;
  logic             err_q, err_d;
  logic             wr_q, wr_d;

  tcm_arb_sel #(
    .MaxStall(MaxStall)
  ) u_sel (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .instr_req_i(instr_req_i),
    .data_req_i (data_req_i),
    .instr_win_o(instr_win),
    .data_win_o (data_win)
  );

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;

  always_comb begin
    granted      = instr_win | data_win;
    sel_addr     = instr_win ? instr_addr_i : data_addr_i;
    sel_off      = sel_addr - BaseAddr;
    sel_word     = MemAw'(sel_off >> 2);
    sel_in_range = in_range(sel_addr, BaseAddr, MemAw);
    mem_en_o     = granted & sel_in_range;
    mem_we_o     = (mem_en_o && data_win && data_we_i) ? data_be_i : 4'b0;
    // Address/wdata only move on a real RAM access to avoid needless toggling
    mem_addr_d   = mem_en_o ? sel_word : mem_addr_q;
    mem_wdata_d  = mem_en_o ? data_wdata_i : mem_wdata_q;
    owner_d      = instr_win ? OWN_INSTR : (data_win ? OWN_DATA : OWN_NONE);
    err_d        = granted & ~sel_in_range;
    wr_d         = data_win & data_we_i;
  end

  assign mem_addr_o  = mem_addr_d;
  assign mem_wdata_o = mem_wdata_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= OWN_NONE;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
    end
  end

  always_comb begin
    instr_rvalid_o = (owner_q == OWN_INSTR);
    data_rvalid_o  = (owner_q == OWN_DATA);
    instr_err_o    = instr_rvalid_o & err_q;
    data_err_o     = data_rvalid_o & err_q;
    instr_rdata_o  = (instr_rvalid_o && !err_q) ? mem_rdata_i : 32'h0;
    data_rdata_o   = (data_rvalid_o && !err_q && !wr_q) ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// tb/tb_tcm_arbiter.sv - randomized and directed bench for tcm_arbiter against a behavioural model
module tb_tcm_arbiter;

  localparam int          MEM_AW    = 10;
  localparam logic [31:0] BASE      = 32'h2000_0000;
  localparam int          MAX_STALL = 4;
  localparam int          DEPTH     = 1 << MEM_AW;

  logic              clk_i, rst_ni;
  logic              instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]       instr_addr_i, instr_rdata_o;
  logic              data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [3:0]        data_be_i;
  logic [31:0]       data_addr_i, data_wdata_i, data_rdata_o;
  logic              mem_en_o;
  logic [3:0]        mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o, mem_rdata_i;

  tcm_arbiter #(
    .MemAw(MEM_AW), .BaseAddr(BASE), .MaxStall(MAX_STALL)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] seed_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_5A5A;
  endfunction

  // Single-port RAM fixture
  logic [31:0] ram [0:DEPTH-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] <= seed_word(i);
    mem_rdata_i <= 32'h0;
    forever begin
      @(posedge clk_i);
      if (mem_en_o) begin
        if (mem_we_o == 4'b0) mem_rdata_i <= ram[mem_addr_o];
        for (int b = 0; b < 4; b++)
          if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          pend_v, pend_instr, pend_err;
  logic [31:0] pend_rdata;
  int          losses;
  bit          rr_last_instr;
  logic [31:0] last_addr, last_wd;
  int          win_log;

  task automatic model_reset();
    pend_v = 0; pend_instr = 0; pend_err = 0; pend_rdata = 0;
    losses = 0; rr_last_instr = 1; last_addr = 0; last_wd = 0;
  endtask

  task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
    bit iw, dw, inr;
    logic [31:0] a, off;
    int w;
    @(negedge clk_i);
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dwe; data_be_i = dbe; data_addr_i = da; data_wdata_i = dwd;
    #1;
    chk("instr_rvalid", instr_rvalid_o, pend_v && pend_instr);
    chk("instr_err",    instr_err_o,    pend_v && pend_instr && pend_err);
    chk("instr_rdata",  instr_rdata_o,  (pend_v && pend_instr) ? pend_rdata : 32'h0);
    chk("data_rvalid",  data_rvalid_o,  pend_v && !pend_instr);
    chk("data_err",     data_err_o,     pend_v && !pend_instr && pend_err);
    chk("data_rdata",   data_rdata_o,   (pend_v && !pend_instr) ? pend_rdata : 32'h0);
    iw = 0; dw = 0;
    if (ir && dr) begin
`ifdef TCM_ARB_RR_EN
      if (rr_last_instr) dw = 1; else iw = 1;
      rr_last_instr = iw;
`else
      if (losses >= MAX_STALL) iw = 1; else dw = 1;
`endif
    end else begin
      iw = ir; dw = dr;
    end
    losses = (ir && !iw) ? losses + 1 : 0;
    chk("instr_gnt", instr_gnt_o, iw);
    chk("data_gnt",  data_gnt_o,  dw);
    a   = iw ? ia : da;
    off = a - BASE;
    inr = (iw || dw) && (off < 32'(4 * DEPTH));
    w   = int'(off / 4) % DEPTH;
    chk("mem_en", mem_en_o, inr);
    chk("mem_we", mem_we_o, (inr && dw && dwe) ? dbe : 4'b0);
    if (inr) begin
      last_addr = 32'(w);
      last_wd   = dwd;
    end
    chk("mem_addr",  32'(mem_addr_o), last_addr);
    chk("mem_wdata", mem_wdata_o, last_wd);
    pend_v     = iw || dw;
    pend_instr = iw;
    pend_err   = (iw || dw) && !inr;
    pend_rdata = (inr && !(dw && dwe)) ? ref_mem[w] : 32'h0;
    if (inr && dw && dwe)
      for (int b = 0; b < 4; b++) if (dbe[b]) ref_mem[w][8*b +: 8] = dwd[8*b +: 8];
    win_log = iw ? 1 : (dw ? 2 : 0);
  endtask

  task automatic idle();
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 0;
    instr_req_i = 0; data_req_i = 0;
    #1;
    chk("rst_instr_rvalid", instr_rvalid_o, 0);
    chk("rst_data_rvalid",  data_rvalid_o,  0);
    chk("rst_instr_err",    instr_err_o,    0);
    chk("rst_data_err",     data_err_o,     0);
    chk("rst_instr_rdata",  instr_rdata_o,  0);
    chk("rst_data_rdata",   data_rdata_o,   0);
    chk("rst_mem_en",       mem_en_o,       0);
    chk("rst_mem_we",       mem_we_o,       0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return BASE + 32'h1000 + 32'($urandom_range(0, 255)) * 4;
    if (r == 1) return BASE - 32'd4;
    return BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [9:0] pat;
    int wait_c, max_wait;
    rst_ni = 0;
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    do_reset();

    // Instr read of word 4
    cycle(1, BASE + 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("t1_mem_addr", 32'(mem_addr_o), 32'd4);
    idle();
    chk("t1_rdata", instr_rdata_o, 32'hDEAD_BEEF);

    // Partial data write to word 2
    cycle(0, 32'h0, 1, 1, 4'b0011, BASE + 32'h8, 32'h1234_5678);
    chk("t2_mem_we", mem_we_o, 4'b0011);
    chk("t2_mem_addr", 32'(mem_addr_o), 32'd2);
    idle();
    chk("t2_rvalid", data_rvalid_o, 1);
    chk("t2_rdata", data_rdata_o, 32'h0);

    // Out-of-range data read
    cycle(0, 32'h0, 1, 0, 4'h0, BASE + 32'h1000, 32'h0);
    chk("t4_gnt", data_gnt_o, 1);
    chk("t4_mem_en", mem_en_o, 0);
    idle();
    chk("t4_err", data_err_o, 1);

    // Sustained contention from a clean state
    do_reset();
    pat = '0; wait_c = 0; max_wait = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, BASE + 32'(i * 4), 1, 0, 4'h0, BASE + 32'h100 + 32'(i * 4), 32'h0);
      wait_c++;
      if (win_log == 1) begin
        pat[i] = 1'b1;
        if (wait_c > max_wait) max_wait = wait_c;
        wait_c = 0;
      end
    end
`ifdef TCM_ARB_RR_EN
    chk("t3_pattern", 32'(pat), 32'h2AA);
`else
    chk("t3_pattern", 32'(pat), 32'h210);
`endif
    chk("t3_max_wait_ok", 32'(max_wait <= MAX_STALL + 1), 32'd1);

    // Reset in the cycle after a grant drops the response
    cycle(1, BASE + 32'h20, 0, 0, 4'h0, 32'h0, 32'h0);
    do_reset();
    idle();

    // Back-to-back instr stream
    for (int i = 0; i < 8; i++) cycle(1, BASE + 32'h40 + 32'(i * 4), 0, 0, 4'h0, 32'h0, 32'h0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rand_addr(), $urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
